debounced_counter_bank: RTL and testbench
=========================================

DEBOUNCED_COUNTER_BANK -- requirements
Module: debounced_counter_bank

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 2, meaning the number of independent switch/counter channels (1..8).
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 250000, meaning consecutive stable clocks required to accept a switch level change (10 ms at 25 MHz; >=1).
REQ-003 The block SHALL have parameter CNT_W, default 4, meaning counter width per channel (1..4).
REQ-004 The block SHALL have parameter MODULUS, default 16, meaning count range 0..MODULUS-1 (2..2**CNT_W).
REQ-005 The block SHALL have port clock, input, 1 bit: single clock for all logic.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port switch_in, input, CHANNELS bits: raw, asynchronous, bouncy switch levels, 1 = pressed.
REQ-008 The block SHALL have port dir, input, CHANNELS bits: per-channel direction, 0 = up, 1 = down.
REQ-009 The block SHALL have port clear, input, 1 bit: synchronous clear of all counters.
REQ-010 The block SHALL have port count, output, CHANNELS*CNT_W bits: channel i at bits [i*CNT_W +: CNT_W].
REQ-011 The block SHALL have port wrap_pulse, output, CHANNELS bits: one-cycle pulse per channel on wrap.
REQ-012 The block SHALL have port seg_n, output, CHANNELS*7 bits: active-low segments, channel i at [i*7 +: 7], bit order {A,B,C,D,E,F,G}, A most significant.

Function
REQ-013 Each switch_in bit SHALL pass through a two-flop synchronizer; its output is s[i].
REQ-014 Each channel SHALL hold debounced state db[i] and a stability counter; the counter increments on each edge where s[i] != db[i] and resets to 0 on any edge where they are equal.
REQ-015 db[i] SHALL take the value of s[i] on the DEBOUNCE_CYCLES-th consecutive edge with s[i] != db[i], and the stability counter SHALL return to 0 on that edge.
REQ-016 A press event SHALL be a 0->1 transition of db[i]; it SHALL be registered and act on the next edge; releases (1->0) SHALL produce no event.
REQ-017 Latency: switch_in high before edge 1 and held SHALL update count on edge DEBOUNCE_CYCLES+3.
REQ-018 On a press event, count[i] SHALL increment when dir[i]=0 and decrement when dir[i]=1; dir SHALL be sampled on the edge that applies the event.
REQ-019 Up from MODULUS-1 SHALL give 0; down from 0 SHALL give MODULUS-1; either case SHALL assert wrap_pulse[i] for exactly that one cycle.
REQ-020 wrap_pulse[i] SHALL be 0 on every cycle without a wrap.
REQ-021 clear=1 SHALL set all counts to 0 and all wrap_pulse bits to 0 on that edge, overriding any coincident press event; the event SHALL be discarded, not deferred.
REQ-022 Channels SHALL be fully independent; simultaneous events on several channels SHALL all apply on the same edge.
REQ-023 seg_n SHALL be registered: it SHALL reflect count one cycle after count changes.
REQ-024 seg_n SHALL use inverted hex patterns 0-F (for example, 0 = 0000001, 1 = 1001111, A = 0001000, F = 0111000).
REQ-025 Bounce shorter than DEBOUNCE_CYCLES SHALL never change db[i] or count[i].

Reset
REQ-026 While reset=1, asynchronously, count SHALL be 0, wrap_pulse 0, seg_n 0000001 per channel, synchronizers 0, db 0, stability counters 0, and the event register 0.
REQ-027 Reset asserted mid-debounce or mid-event SHALL discard all progress; no event SHALL be applied after release for that press.
REQ-028 A switch held through reset release SHALL be treated as a new press: one count, DEBOUNCE_CYCLES+3 edges after release.

Verification (DEBOUNCE_CYCLES=4, CHANNELS=2, MODULUS=10, CNT_W=4)
REQ-029 Held press: switch_in[0]=1 from edge 1 -> count[3:0]=1 at edge 7; seg_n[6:0]=1001111 at edge 8; channel 1 stays 0.
REQ-030 Bounce: switch_in[0] toggles 1,0,1,0 on successive edges, then stays 0 -> count unchanged and wrap_pulse=00 throughout.
REQ-031 Wrap both ways: 10 up-presses on ch1 -> 9 then 0 with wrap_pulse[1]=1 for one cycle; dir[1]=1 and one press -> 9 with wrap_pulse[1]=1.
REQ-032 Clear collision: clear=1 on the edge a ch0 event applies -> count=0 and wrap_pulse=0; no increment follows.
REQ-033 Simultaneous: both switches pressed on the same edge, dir=2'b10 -> ch0=1 and ch1=9 on the same edge.
REQ-034 Reset mid-debounce: reset pulsed two edges after switch_in[0] rises and the switch is held -> all outputs at reset values; count=1 exactly 7 edges after release.

Source files
------------

// File: rtl/debounced_counter_bank_if.sv
// Bus bundle for debounced_counter_bank: switch/dir/clear inputs, count/wrap/segment outputs.
interface debounced_counter_bank_if #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned CNT_W    = 4
) ();

  logic [CHANNELS-1:0]       switch_in;
  logic [CHANNELS-1:0]       dir;
  logic                      clear;
  logic [CHANNELS*CNT_W-1:0] count;
  logic [CHANNELS-1:0]       wrap_pulse;
  logic [CHANNELS*7-1:0]     seg_n;

  // Stimulus side: drives switches, direction and clear; observes counters.
  modport master (
    output switch_in,
    output dir,
    output clear,
    input  count,
    input  wrap_pulse,
    input  seg_n
  );

  // Counter bank side.
  modport slave (
    input  switch_in,
    input  dir,
    input  clear,
    output count,
    output wrap_pulse,
    output seg_n
  );

endinterface

// File: rtl/debounced_counter_bank.sv
// Bank of independent channels: synchronize and debounce a switch, count presses up/down
// modulo MODULUS, pulse on wrap, and drive an active-low seven-segment hex digit per channel.
module debounced_counter_bank #(
  parameter int unsigned CHANNELS        = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned CNT_W           = 4,
  parameter int unsigned MODULUS         = 16
) (
  input logic                      clock,
  input logic                      reset,
  debounced_counter_bank_if.slave  bus
);

  // Stability counter only needs to reach DEBOUNCE_CYCLES-1; the acceptance edge resets it.
  localparam int unsigned StabW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [StabW-1:0] StabLast = StabW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntMax   = CNT_W'(MODULUS - 1);
  localparam logic [6:0]       SegZero  = 7'b0000001;

  logic [CHANNELS-1:0] sync1_q, sync2_q;
  logic [CHANNELS-1:0] db_q, db_d;
  logic [StabW-1:0]    stab_q [CHANNELS];
  logic [StabW-1:0]    stab_d [CHANNELS];
  logic [CHANNELS-1:0] event_q, event_d;
  logic [CNT_W-1:0]    count_q [CHANNELS];
  logic [CNT_W-1:0]    count_d [CHANNELS];
  logic [CHANNELS-1:0] wrap_q, wrap_d;
  logic [6:0]          seg_q [CHANNELS];
  logic [6:0]          seg_d [CHANNELS];

  // Active-low {A..G} pattern for one hex digit.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
    logic [6:0] seg;
    case (value)
      4'h0:    seg = 7'b0000001;
      4'h1:    seg = 7'b1001111;
      4'h2:    seg = 7'b0010010;
      4'h3:    seg = 7'b0000110;
      4'h4:    seg = 7'b1001100;
      4'h5:    seg = 7'b0100100;
      4'h6:    seg = 7'b0100000;
      4'h7:    seg = 7'b0001111;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0000100;
      4'ha:    seg = 7'b0001000;
      4'hb:    seg = 7'b1100000;
      4'hc:    seg = 7'b0110001;
      4'hd:    seg = 7'b1000010;
      4'he:    seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
    return seg;
  endfunction

  // Two-flop synchronizer for the raw switch levels.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus.switch_in;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: accept a level after DEBOUNCE_CYCLES consecutive mismatching edges; a rising
  // acceptance raises the press event for one cycle.
  always_comb begin
    db_d    = db_q;
    event_d = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      stab_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (stab_q[i] == StabLast) begin
          db_d[i]    = sync2_q[i];
          event_d[i] = sync2_q[i];
        end else begin
          stab_d[i] = stab_q[i] + StabW'(1);
        end
      end
    end
  end

  // Counter next state: clear wins over events; wraps in both directions raise wrap_d.
  always_comb begin
    wrap_d = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      count_d[i] = count_q[i];
      if (bus.clear) begin
        count_d[i] = '0;
      end else if (event_q[i]) begin
        if (!bus.dir[i]) begin
          if (count_q[i] == CntMax) begin
            count_d[i] = '0;
            wrap_d[i]  = 1'b1;
          end else begin
            count_d[i] = count_q[i] + CNT_W'(1);
          end
        end else begin
          if (count_q[i] == '0) begin
            count_d[i] = CntMax;
            wrap_d[i]  = 1'b1;
          end else begin
            count_d[i] = count_q[i] - CNT_W'(1);
          end
        end
      end
    end
  end

  // Segment decode follows the registered count, so the display lags count by one cycle.
  always_comb begin
    for (int i = 0; i < int'(CHANNELS); i++) begin
      seg_d[i] = hex_to_seg(4'(count_q[i]));
    end
  end

  // Debounce state, event register, counters, wrap pulses and segment registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      db_q    <= '0;
      event_q <= '0;
      wrap_q  <= '0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        stab_q[i]  <= '0;
        count_q[i] <= '0;
        seg_q[i]   <= SegZero;
      end
    end else begin
      db_q    <= db_d;
      event_q <= event_d;
      wrap_q  <= wrap_d;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        stab_q[i]  <= stab_d[i];
        count_q[i] <= count_d[i];
        seg_q[i]   <= seg_d[i];
      end
    end
  end

  for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_out
    assign bus.count[g*CNT_W +: CNT_W] = count_q[g];
    assign bus.seg_n[g*7 +: 7]         = seg_q[g];
  end

  assign bus.wrap_pulse = wrap_q;

endmodule

// File: tb/tb_debounced_counter_bank.sv
// Directed self-checking bench for debounced_counter_bank (DEBOUNCE_CYCLES=4, MODULUS=10).
module tb_debounced_counter_bank;

  logic clock;
  logic reset;
  int   errors;
  int   checks;

  // Active-low {A..G} patterns for digits 0..9.
  logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                               7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  debounced_counter_bank_if #(.CHANNELS(2), .CNT_W(4)) bus ();

  debounced_counter_bank #(
    .CHANNELS       (2),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (4),
    .MODULUS        (10)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance n rising edges, leaving the bench 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  function automatic logic [3:0] cnt(input int ch);
    return bus.count[ch*4 +: 4];
  endfunction

  function automatic logic [6:0] seg(input int ch);
    return bus.seg_n[ch*7 +: 7];
  endfunction

  // Switch goes high before the next edge; count lands on the 7th edge.
  task automatic press(input int ch);
    bus.switch_in[ch] = 1'b1;
    tick(7);
  endtask

  // Release and wait until the debounced level has returned to 0.
  task automatic release_sw(input int ch, input logic [6:0] seg_exp);
    bus.switch_in[ch] = 1'b0;
    tick(1);
    check("release_wrap_low", 32'(bus.wrap_pulse), 32'h0);
    check("release_seg", 32'(seg(ch)), 32'(seg_exp));
    tick(6);
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    reset         = 1'b0;
    bus.switch_in = '0;
    bus.dir       = '0;
    bus.clear     = 1'b0;

    // Reset values, asserted asynchronously.
    #2 reset = 1'b1;
    #1;
    check("reset_count", 32'(bus.count), 32'h0);
    check("reset_wrap", 32'(bus.wrap_pulse), 32'h0);
    check("reset_seg", 32'(bus.seg_n), 32'(14'b0000001_0000001));
    tick(2);
    reset = 1'b0;

    // Held press on ch0: count at edge 7, display at edge 8.
    bus.switch_in[0] = 1'b1;
    tick(6);
    check("held_edge6_count", 32'(bus.count), 32'h0);
    tick(1);
    check("held_edge7_count0", 32'(cnt(0)), 32'h1);
    check("held_edge7_seg_lags", 32'(seg(0)), 32'(7'b0000001));
    tick(1);
    check("held_edge8_seg0", 32'(seg(0)), 32'(7'b1001111));
    check("held_edge8_count1", 32'(cnt(1)), 32'h0);
    release_sw(0, 7'b1001111);
    check("release_no_event", 32'(bus.count), 32'h01);

    // Bounce shorter than the debounce window.
    for (int i = 0; i < 12; i++) begin
      bus.switch_in[0] = (i < 4) ? ~i[0] : 1'b0;
      tick(1);
      check("bounce_count", 32'(bus.count), 32'h01);
      check("bounce_wrap", 32'(bus.wrap_pulse), 32'h0);
    end

    // Ten up-presses on ch1: 1..9 then wrap to 0.
    for (int i = 1; i <= 10; i++) begin
      press(1);
      check("up_count1", 32'(cnt(1)), 32'(i % 10));
      check("up_wrap", 32'(bus.wrap_pulse), (i == 10) ? 32'h2 : 32'h0);
      release_sw(1, seg_tab[i % 10]);
    end

    // Down from 0 wraps to 9.
    bus.dir = 2'b10;
    press(1);
    check("down_count1", 32'(cnt(1)), 32'h9);
    check("down_wrap", 32'(bus.wrap_pulse), 32'h2);
    release_sw(1, 7'b0000100);
    bus.dir = 2'b00;

    // Clear on the edge the ch0 event applies.
    bus.switch_in[0] = 1'b1;
    tick(6);
    check("clear_pre_count", 32'(bus.count), 32'h91);
    bus.clear = 1'b1;
    tick(1);
    check("clear_count", 32'(bus.count), 32'h0);
    check("clear_wrap", 32'(bus.wrap_pulse), 32'h0);
    bus.clear = 1'b0;
    tick(3);
    check("clear_no_deferred", 32'(bus.count), 32'h0);
    release_sw(0, 7'b0000001);

    // Simultaneous presses, ch0 up and ch1 down.
    bus.dir       = 2'b10;
    bus.switch_in = 2'b11;
    tick(6);
    check("simul_edge6", 32'(bus.count), 32'h0);
    tick(1);
    check("simul_count", 32'(bus.count), 32'h91);
    check("simul_wrap", 32'(bus.wrap_pulse), 32'h2);
    bus.switch_in = 2'b00;
    tick(7);
    bus.dir = 2'b00;
    check("simul_seg", 32'(bus.seg_n), 32'({7'b0000100, 7'b1001111}));

    // Reset two edges into a ch0 press, switch held through release.
    bus.switch_in[0] = 1'b1;
    tick(2);
    reset = 1'b1;
    #1;
    check("midrst_count", 32'(bus.count), 32'h0);
    check("midrst_wrap", 32'(bus.wrap_pulse), 32'h0);
    check("midrst_seg", 32'(bus.seg_n), 32'(14'b0000001_0000001));
    tick(1);
    reset = 1'b0;
    tick(6);
    check("midrst_edge6", 32'(bus.count), 32'h0);
    tick(1);
    check("midrst_edge7", 32'(bus.count), 32'h01);
    tick(5);
    check("midrst_single", 32'(bus.count), 32'h01);
    check("midrst_seg_after", 32'(seg(0)), 32'(7'b1001111));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
